bemf_scheduler: RTL and testbench
=================================

# bemf_scheduler

Time-multiplexes the single shared back-EMF ADC across the four motor axes. Once per programmed period, it steps through each enabled axis in turn. For each axis it removes drive (the axis coasts), waits a settle time, runs one ADC conversion, posts the result, and restores drive. It sits between the register interface and the motor bridge logic. It drives the per-axis Active lines, and the bridge logic uses the inverse of each Active line as that axis's measure input.

## Interface
Parameters:
- AXES, 4, number of motor axes scheduled (fixed 4 in this design)
- ADC_W, 10, ADC result width

Ports:
- Clk  in  1  system clock; single clock domain
- ResetN  in  1  asynchronous, active-low reset
- AxisEnable  in  AXES  per-axis scan enable, sampled at scan start
- Period  in  16  scan period in Clk cycles; 0 disables scanning
- SettleCycles  in  8  coast time before conversion; 0 allowed
- Active  out  AXES  1 = axis driven, 0 = axis coasting for measurement
- AdcStart  out  1  one-cycle conversion request
- AdcChan  out  2  axis index for the current conversion
- AdcBusy  in  1  ADC engine busy; AdcStart is never issued while high
- AdcDone  in  1  one-cycle pulse, result valid on AdcData
- AdcData  in  ADC_W  conversion result
- ResultWr  out  1  one-cycle write strobe to the result registers
- ResultAxis  out  2  axis index for ResultWr
- ResultData  out  ADC_W  registered AdcData
- ScanDone  out  1  one-cycle pulse at end of scan (interrupt status set)
- Overrun  out  1  one-cycle pulse when a period tick arrives mid-scan

## Operation
- Period timer:
  - Free-running counter runs 0..Period-1 and issues a tick on wrap.
  - Period=0 holds the counter at 0 and issues no ticks.
  - A change to Period takes effect at the next wrap.
- States and transitions:
  - IDLE: on a tick, latch AxisEnable into EnMask and set Axis=0. Go to SELECT, or pulse ScanDone and stay in IDLE if EnMask=0.
  - SELECT: if EnMask[Axis], clear Active[Axis] and load the settle counter, then go to SETTLE. Otherwise go to NEXT.
  - SETTLE: count down SettleCycles. At 0, go to REQ.
  - REQ: wait for AdcBusy=0. Then pulse AdcStart with AdcChan=Axis and go to WAIT.
  - WAIT: on AdcDone, register the data, set Active[Axis]=1, pulse ResultWr, and go to NEXT.
  - NEXT: if Axis=3, pulse ScanDone and go to IDLE. Otherwise increment Axis and go to SELECT.
- At most one Active bit is 0 at any time. All other Active bits stay 1.
- A tick while not in IDLE produces an Overrun pulse. That tick is dropped and the scan continues unaffected.
- An AdcDone outside WAIT is ignored.
- AxisEnable changes during a scan do not affect the current scan.
- Reset mid-scan: all Active bits return to 1 immediately (asynchronous), and no ResultWr or ScanDone is issued.

## Timing
- Reset values:
  - Active=all 1s.
  - AdcStart, ResultWr, ScanDone, Overrun all 0.
  - AdcChan=0, ResultAxis=0, ResultData=0.
  - State=IDLE, timer=0.
- The Active[Axis] falling edge is registered on the cycle after SELECT.
- With SettleCycles=N and AdcBusy=0, AdcStart is asserted N+1 cycles after Active[Axis] falls.
- ResultWr and Active[Axis] rising occur on the cycle after AdcDone.
  - ResultData/ResultAxis are valid with ResultWr.
- ScanDone asserts one cycle after the last axis's ResultWr, or after its skip.
- Minimum per-axis time: SettleCycles + 3 cycles + ADC conversion time.

## Configuration
- BEMF_TIMEOUT_EN defined:
  - In WAIT, a 12-bit counter aborts the conversion if AdcDone is absent for 4095 cycles.
  - On abort: restore Active[Axis], issue no ResultWr, pulse output AdcTimeout for one cycle, and go to NEXT.
- BEMF_TIMEOUT_EN undefined:
  - WAIT waits indefinitely.
  - The AdcTimeout port is absent.

## Structure
- Package bemf_sched_pkg holds:
  - the state enum (IDLE, SELECT, SETTLE, REQ, WAIT, NEXT)
  - AXES, ADC_W, and TIMEOUT_CYCLES=4095
- Sub-module bemf_period_timer contains the period counter and tick generation, so it can be reused by the servo and GPIO scan logic.

## Test plan
- Enable pattern and one full scan:
  - Stimulus: Period=200, SettleCycles=5, AxisEnable=4'b1011, ADC model with 10-cycle conversions returning 0x100+axis.
  - Response: ResultWr for axes 0, 1, 3 with data 0x100, 0x101, 0x103. Axis 2 Active never falls. ScanDone once per 200 cycles.
- Settle timing:
  - Stimulus: SettleCycles=0, then 255.
  - Response: AdcStart exactly 1 cycle, then 256 cycles, after the Active fall. Only one Active bit is 0 at any time.
- Busy and stray Done:
  - Stimulus: hold AdcBusy=1 for 30 cycles during REQ; inject a stray AdcDone during SETTLE.
  - Response: AdcStart delayed until AdcBusy falls. The stray pulse produces no ResultWr.
- Overrun:
  - Stimulus: Period=20 with 10-cycle conversions on 4 axes.
  - Response: Overrun pulses. Scan results stay complete and in order 0..3.
- Reset mid-scan:
  - Stimulus: deassert ResetN during WAIT on axis 1.
  - Response: Active=4'b1111 within the same cycle. No ResultWr. First tick after reset restarts at axis 0.
- Timeout (BEMF_TIMEOUT_EN only):
  - Stimulus: never return AdcDone.
  - Response: AdcTimeout 4095 cycles after AdcStart. Active restored. Scan proceeds to the next axis.

Source files
------------

// File: rtl/bemf_sched_pkg.sv
// Shared state encoding and sizing constants for the back-EMF measurement scheduler.
package bemf_sched_pkg;
  localparam int AXES           = 4;
  localparam int ADC_W          = 10;
  localparam int TIMEOUT_CYCLES = 4095;

  typedef enum logic [2:0] {IDLE, SELECT, SETTLE, REQ, WAIT, NEXT} state_t;
endpackage

// File: rtl/bemf_period_timer.sv
// Free-running period counter with a one-cycle tick on wrap; period 0 parks it.
module bemf_period_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] period,
  output logic        tick
);
  logic [15:0] cnt;
  logic [15:0] per_q;

  // The active period is only reloaded at a wrap (or while parked at 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      per_q <= '0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (per_q == '0) begin
        cnt   <= '0;
        per_q <= period;
      end else if (cnt == per_q - 16'd1) begin
        cnt   <= '0;
        tick  <= 1'b1;
        per_q <= period;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end
endmodule

// File: rtl/bemf_scheduler.sv
// Shares one back-EMF ADC across the motor axes, coasting one axis at a time per scan.
// Optional BEMF_TIMEOUT_EN adds a conversion watchdog and the AdcTimeout pulse.
module bemf_scheduler #(
  parameter int AXES  = bemf_sched_pkg::AXES,
  parameter int ADC_W = bemf_sched_pkg::ADC_W
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic [AXES-1:0]  AxisEnable,
  input  logic [15:0]      Period,
  input  logic [7:0]       SettleCycles,
  output logic [AXES-1:0]  Active,
  output logic             AdcStart,
  output logic [1:0]       AdcChan,
  input  logic             AdcBusy,
  input  logic             AdcDone,
  input  logic [ADC_W-1:0] AdcData,
  output logic             ResultWr,
  output logic [1:0]       ResultAxis,
  output logic [ADC_W-1:0] ResultData,
  output logic             ScanDone,
  output logic             Overrun
`ifdef BEMF_TIMEOUT_EN
  ,
  output logic             AdcTimeout
`endif
);
  import bemf_sched_pkg::*;

  state_t          state;
  logic [1:0]      axis;
  logic [AXES-1:0] en_mask;
  logic [7:0]      settle_cnt;
  logic            tick;
  logic            start_now;
`ifdef BEMF_TIMEOUT_EN
  logic [11:0]     to_cnt;
`endif

  bemf_period_timer u_timer (
    .clk    (Clk),
    .rst_n  (ResetN),
    .period (Period),
    .tick   (tick)
  );

  // Settle expiry issues the request directly so AdcStart lands N+1 cycles after coast.
  assign start_now = !AdcBusy &&
                     (state == REQ || (state == SETTLE && settle_cnt == '0));

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state      <= IDLE;
      axis       <= '0;
      en_mask    <= '0;
      settle_cnt <= '0;
      Active     <= '1;
      AdcStart   <= 1'b0;
      AdcChan    <= '0;
      ResultWr   <= 1'b0;
      ResultAxis <= '0;
      ResultData <= '0;
      ScanDone   <= 1'b0;
      Overrun    <= 1'b0;
`ifdef BEMF_TIMEOUT_EN
      to_cnt     <= '0;
      AdcTimeout <= 1'b0;
`endif
    end else begin
      AdcStart <= 1'b0;
      ResultWr <= 1'b0;
      ScanDone <= 1'b0;
      Overrun  <= tick && (state != IDLE);
`ifdef BEMF_TIMEOUT_EN
      AdcTimeout <= 1'b0;
`endif
      if (start_now) begin
        AdcStart <= 1'b1;
        AdcChan  <= axis;
        state    <= WAIT;
`ifdef BEMF_TIMEOUT_EN
        to_cnt   <= '0;
`endif
      end
      case (state)
        IDLE: if (tick) begin
          en_mask <= AxisEnable;
          axis    <= '0;
          if (AxisEnable == '0) ScanDone <= 1'b1;
          else                  state    <= SELECT;
        end
        SELECT: if (en_mask[axis]) begin
          Active[axis] <= 1'b0;
          settle_cnt   <= SettleCycles;
          state        <= SETTLE;
        end else begin
          state <= NEXT;
        end
        SETTLE: begin
          if (settle_cnt != '0)  settle_cnt <= settle_cnt - 8'd1;
          else if (!start_now)   state      <= REQ;
        end
        REQ: ;
        WAIT: begin
          if (AdcDone) begin
            ResultData   <= AdcData;
            ResultAxis   <= axis;
            ResultWr     <= 1'b1;
            Active[axis] <= 1'b1;
            state        <= NEXT;
          end
`ifdef BEMF_TIMEOUT_EN
          else if (to_cnt == 12'(TIMEOUT_CYCLES - 1)) begin
            Active[axis] <= 1'b1;
            AdcTimeout   <= 1'b1;
            state        <= NEXT;
          end else begin
            to_cnt <= to_cnt + 12'd1;
          end
`endif
        end
        NEXT: if (axis == 2'(AXES - 1)) begin
          ScanDone <= 1'b1;
          state    <= IDLE;
        end else begin
          axis  <= axis + 2'd1;
          state <= SELECT;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bemf_scheduler.sv
// Scoreboard bench for bemf_scheduler: ADC model returns 0x100+channel after ~10 cycles.
module tb_bemf_scheduler;
  localparam int AXES  = 4;
  localparam int ADC_W = 10;
  localparam int CONV  = 10;

  logic             Clk = 1'b0;
  logic             ResetN = 1'b0;
  logic [AXES-1:0]  AxisEnable = '0;
  logic [15:0]      Period = '0;
  logic [7:0]       SettleCycles = '0;
  logic [AXES-1:0]  Active;
  logic             AdcStart;
  logic [1:0]       AdcChan;
  logic             AdcBusy, AdcDone;
  logic [ADC_W-1:0] AdcData;
  logic             ResultWr;
  logic [1:0]       ResultAxis;
  logic [ADC_W-1:0] ResultData;
  logic             ScanDone, Overrun;
`ifdef BEMF_TIMEOUT_EN
  logic             AdcTimeout;
`endif

  logic             busy_m = 1'b0, done_m = 1'b0, busy_force = 1'b0, stray_done = 1'b0;
  logic [ADC_W-1:0] data_m = '0;
  logic [1:0]       conv_ch = '0;
  int               conv_cnt = 0;
  int               hold_chan = -1;
  int               cyc = 0;

  assign AdcBusy = busy_m | busy_force;
  assign AdcDone = done_m | stray_done;
  assign AdcData = data_m;

  bemf_scheduler #(.AXES(AXES), .ADC_W(ADC_W)) dut (
    .Clk(Clk), .ResetN(ResetN), .AxisEnable(AxisEnable), .Period(Period),
    .SettleCycles(SettleCycles), .Active(Active), .AdcStart(AdcStart), .AdcChan(AdcChan),
    .AdcBusy(AdcBusy), .AdcDone(AdcDone), .AdcData(AdcData), .ResultWr(ResultWr),
    .ResultAxis(ResultAxis), .ResultData(ResultData), .ScanDone(ScanDone), .Overrun(Overrun)
`ifdef BEMF_TIMEOUT_EN
    , .AdcTimeout(AdcTimeout)
`endif
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // ADC engine model; a held channel never completes.
  always @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      busy_m <= 1'b0; done_m <= 1'b0; conv_cnt <= 0;
    end else begin
      done_m <= 1'b0;
      if (AdcStart) begin
        busy_m <= 1'b1; conv_ch <= AdcChan; conv_cnt <= CONV - 1;
      end else if (busy_m && int'(conv_ch) != hold_chan) begin
        if (conv_cnt == 0) begin
          busy_m <= 1'b0; done_m <= 1'b1; data_m <= 10'h100 + 10'(conv_ch);
        end else begin
          conv_cnt <= conv_cnt - 1;
        end
      end
    end
  end

  logic [11:0] sb[$];
  int checks = 0, errors = 0;
  int n_done = 0, n_ovr = 0, n_wr = 0, n_start = 0, last_done = 0, prev_done = 0;
  bit a2_fell = 1'b0;

  task automatic monitor();
    logic [11:0] exp_r;
    forever begin
      @(negedge Clk);
      if (ResetN) begin
        checks++;
        if ($countones(~Active) > 1 || (AdcStart && AdcBusy)) begin
          errors++;
          $display("FAIL bus_rules active=%b start=%b busy=%b required one coasting max, no start while busy",
                   Active, AdcStart, AdcBusy);
        end
        if (!Active[2]) a2_fell = 1'b1;
        if (AdcStart) n_start++;
        if (Overrun) n_ovr++;
        if (ScanDone) begin n_done++; prev_done = last_done; last_done = cyc; end
        if (ResultWr) begin
          n_wr++;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL result_unexpected axis=%0d data=%h required no write", ResultAxis, ResultData);
          end else begin
            exp_r = sb.pop_front();
            if ({ResultAxis, ResultData} !== exp_r) begin
              errors++;
              $display("FAIL result got axis=%0d data=%h required axis=%0d data=%h",
                       ResultAxis, ResultData, exp_r[11:10], exp_r[9:0]);
            end
          end
        end
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin @(negedge Clk); #2; end
  endtask

  task automatic wait_done(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (n_done >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_fall(input int ax, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (!Active[ax]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int ch, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (AdcStart && (ch < 0 || int'(AdcChan) == ch)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    ResetN = 1'b0; Period = '0; AxisEnable = '0; SettleCycles = '0;
    busy_force = 1'b0; stray_done = 1'b0; hold_chan = -1;
    sb.delete();
    step(3);
    ResetN = 1'b1;
  endtask

  task automatic test_reset();
    ResetN = 1'b0;
    step(2);
    checks++;
    if ({Active, AdcStart, AdcChan, ResultWr, ResultAxis, ResultData, ScanDone, Overrun} !==
        {4'b1111, 1'b0, 2'd0, 1'b0, 2'd0, 10'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values active=%b start=%b chan=%0d wr=%b rax=%0d rdata=%h done=%b ovr=%b required 1111/0",
               Active, AdcStart, AdcChan, ResultWr, ResultAxis, ResultData, ScanDone, Overrun);
    end
    ResetN = 1'b1;
    step(20);
    checks++;
    if (Active !== 4'b1111 || n_done != 0 || n_start != 0) begin
      errors++;
      $display("FAIL period_zero active=%b done=%0d starts=%0d required 1111/0/0", Active, n_done, n_start);
    end
  endtask

  task automatic test_scan();
    logic [3:0] mask = 4'b1011;
    int w0, o0, d0;
    bit ok;
    do_reset();
    a2_fell = 1'b0; w0 = n_wr; o0 = n_ovr; d0 = n_done;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 4; a++)
        if (mask[a]) sb.push_back({2'(a), 10'(256 + a)});
    Period = 16'd200; SettleCycles = 8'd5; AxisEnable = mask;
    wait_done(d0 + 2, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_timeout done=%0d required %0d", n_done - d0, 2); end
    checks++;
    if (last_done - prev_done != 200) begin
      errors++; $display("FAIL scan_period got %0d required 200", last_done - prev_done);
    end
    checks++;
    if (n_wr - w0 != 6 || sb.size() != 0 || a2_fell || n_ovr != o0) begin
      errors++;
      $display("FAIL scan_summary writes=%0d left=%0d a2_fell=%b ovr=%0d required 6/0/0/0",
               n_wr - w0, sb.size(), a2_fell, n_ovr - o0);
    end
  endtask

  task automatic test_settle(input int n);
    int t0, d0;
    bit ok;
    do_reset();
    d0 = n_done;
    sb.push_back({2'd0, 10'h100});
    Period = 16'd600; SettleCycles = 8'(n); AxisEnable = 4'b0001;
    wait_fall(0, 1000, ok);
    t0 = cyc;
    if (ok) wait_start(-1, 400, ok);
    checks++;
    if (!ok || cyc - t0 != n + 1) begin
      errors++; $display("FAIL settle_%0d got %0d required %0d ok=%b", n, cyc - t0, n + 1, ok);
    end
    wait_done(d0 + 1, 400, ok);
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++; $display("FAIL settle_%0d_result ok=%b left=%0d required 1/0", n, ok, sb.size());
    end
  endtask

  task automatic test_busy_stray();
    int s0, b, w0, d0;
    bit ok;
    do_reset();
    w0 = n_wr; d0 = n_done;
    sb.push_back({2'd0, 10'h100});
    Period = 16'd300; SettleCycles = 8'd5; AxisEnable = 4'b0001;
    wait_fall(0, 400, ok);
    busy_force = 1'b1; stray_done = 1'b1;
    step(1);
    stray_done = 1'b0;
    s0 = n_start;
    step(29);
    checks++;
    if (!ok || n_start != s0) begin
      errors++; $display("FAIL busy_hold ok=%b starts=%0d required 0", ok, n_start - s0);
    end
    busy_force = 1'b0;
    b = cyc;
    wait_start(-1, 50, ok);
    checks++;
    if (!ok || cyc != b + 1) begin
      errors++; $display("FAIL busy_release got %0d required 1 ok=%b", cyc - b, ok);
    end
    wait_done(d0 + 1, 100, ok);
    checks++;
    if (!ok || n_wr - w0 != 1 || sb.size() != 0) begin
      errors++; $display("FAIL stray_done writes=%0d left=%0d required 1/0", n_wr - w0, sb.size());
    end
  endtask

  task automatic test_overrun();
    int w0, o0, o1, d0;
    bit ok;
    do_reset();
    w0 = n_wr; o0 = n_ovr; d0 = n_done;
    for (int a = 0; a < 4; a++) sb.push_back({2'(a), 10'(256 + a)});
    Period = 16'd20; SettleCycles = 8'd0; AxisEnable = 4'b1111;
    wait_fall(0, 100, ok);
    AxisEnable = 4'b0000;
    wait_done(d0 + 1, 300, ok);
    checks++;
    if (!ok || n_ovr - o0 < 2) begin
      errors++; $display("FAIL overrun_pulses got %0d required >=2 ok=%b", n_ovr - o0, ok);
    end
    o1 = n_ovr;
    step(60);
    checks++;
    if (n_wr - w0 != 4 || sb.size() != 0 || n_ovr != o1) begin
      errors++;
      $display("FAIL overrun_results writes=%0d left=%0d late_ovr=%0d required 4/0/0",
               n_wr - w0, sb.size(), n_ovr - o1);
    end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    bit ok;
    do_reset();
    sb.push_back({2'd0, 10'h100});
    hold_chan = 1;
    Period = 16'd100; SettleCycles = 8'd2; AxisEnable = 4'b0011;
    wait_start(1, 300, ok);
    step(3);
    checks++;
    if (!ok || Active !== 4'b1101) begin
      errors++; $display("FAIL mid_wait active=%b required 1101 ok=%b", Active, ok);
    end
    w0 = n_wr; d0 = n_done;
    ResetN = 1'b0;
    #1;
    checks++;
    if (Active !== 4'b1111 || sb.size() != 0) begin
      errors++; $display("FAIL async_reset active=%b left=%0d required 1111/0", Active, sb.size());
    end
    step(5);
    checks++;
    if (n_wr != w0 || n_done != d0 || ResultWr !== 1'b0 || ScanDone !== 1'b0) begin
      errors++; $display("FAIL reset_quiet writes=%0d done=%0d required 0/0", n_wr - w0, n_done - d0);
    end
    hold_chan = -1;
    sb.push_back({2'd0, 10'h100});
    sb.push_back({2'd1, 10'h101});
    ResetN = 1'b1;
    wait_done(d0 + 1, 400, ok);
    checks++;
    if (!ok || n_wr - w0 != 2 || sb.size() != 0) begin
      errors++; $display("FAIL restart writes=%0d left=%0d required 2/0 ok=%b", n_wr - w0, sb.size(), ok);
    end
  endtask

`ifdef BEMF_TIMEOUT_EN
  task automatic test_timeout();
    int t0, w0, d0;
    bit ok;
    do_reset();
    w0 = n_wr; d0 = n_done;
    hold_chan = 0;
    Period = 16'd5000; SettleCycles = 8'd0; AxisEnable = 4'b0001;
    wait_start(0, 6000, ok);
    t0 = cyc;
    for (int i = 0; i < 4200 && ok; i++) begin
      step(1);
      if (AdcTimeout) break;
    end
    checks++;
    if (!ok || AdcTimeout !== 1'b1 || cyc - t0 != 4095) begin
      errors++; $display("FAIL timeout_latency got %0d required 4095", cyc - t0);
    end
    checks++;
    if (Active !== 4'b1111) begin
      errors++; $display("FAIL timeout_active got %b required 1111", Active);
    end
    wait_done(d0 + 1, 5, ok);
    checks++;
    if (!ok || n_wr != w0) begin
      errors++; $display("FAIL timeout_next done_ok=%b writes=%0d required 1/0", ok, n_wr - w0);
    end
  endtask
`endif

  initial begin
    fork monitor(); join_none
    test_reset();
    test_scan();
    test_settle(0);
    test_settle(255);
    test_busy_stray();
    test_overrun();
    test_reset_mid();
`ifdef BEMF_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
